// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   IMEM_ADDR_WIDTH / IMEM_DATA_WIDTH / IMEM_DEPTH : text-segment geometry
//   imem_addr_t / imem_word_t                      : address and instruction types
//   loader_state_t                                 : loader FSM encoding
//   accepts_byte()                                 : states that assert byte_ready
package imem_pkg;

  localparam int IMEM_ADDR_WIDTH = 5;
  localparam int IMEM_DATA_WIDTH = 16;
  localparam int IMEM_DEPTH      = 32;

  typedef logic [IMEM_ADDR_WIDTH-1:0] imem_addr_t;
  typedef logic [IMEM_DATA_WIDTH-1:0] imem_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CK_HI,
    ST_CK_LO,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  // States in which the loader takes a byte from the stream.
  function automatic logic accepts_byte(input loader_state_t s);
    return (s == ST_HI) || (s == ST_LO) || (s == ST_CK_HI) || (s == ST_CK_LO);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the host/UART byte source and the loader.
//   byte_in    : stream data (8 bits)
//   byte_valid : source has a byte on byte_in
//   byte_ready : loader accepts a byte this cycle
// A byte moves on every rising clk edge where byte_valid && byte_ready.
//   master : byte source
//   slave  : loader
interface imem_loader_if;

  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/imem_wr.sv
// Writable instruction RAM, IMEM_DEPTH x IMEM_DATA_WIDTH.
//   clk     : write clock, rising edge
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : instruction word to store
//   rd_addr : fetch address
//   rd_data : instruction at rd_addr (combinational read)
module imem_wr
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  imem_addr_t wr_addr,
  input  imem_word_t wr_data,
  input  imem_addr_t rd_addr,
  output imem_word_t rd_data
);

  imem_word_t mem [IMEM_DEPTH];

  // NOTE: the array has no reset; contents are only meaningful after the
  // loader has written them, and a reset port would block RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Takes a big-endian byte stream (high byte first), assembles 16-bit words,
// writes them to addresses 0..WORD_COUNT-1, then compares a trailing 16-bit
// checksum (sum of all words mod 2^16). The CPU is held in reset until a
// load completes with a matching checksum.
//   clk, rst_n    : clock and asynchronous active-low reset
//   start         : begin a load (honoured in IDLE, DONE and ERR only)
//   bus           : byte-stream handshake (byte_in / byte_valid / byte_ready)
//   wr_en         : one-cycle instruction RAM write strobe per word
//   wr_addr       : RAM write address (holds when wr_en=0)
//   wr_data       : RAM write data (holds when wr_en=0)
//   cpu_hold      : 1 = CPU held in reset
//   busy          : load in progress
//   done          : last load succeeded
//   error         : last load had a checksum mismatch
//   words_written : words written in the current or last load
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = IMEM_DATA_WIDTH,  // two bytes per word; only 16 is meaningful
  parameter int WORD_COUNT = IMEM_DEPTH        // 1..2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  imem_loader_if.slave          bus,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);

  loader_state_t state, next_state;

  logic                  byte_ready;
  logic                  xfer;
  logic [7:0]            hi_q;
  logic [7:0]            ck_hi_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] ck_word;

  // Registered output values decoded from next_state.
  logic byte_ready_d;
  logic wr_en_d;
  logic busy_d;
  logic done_d;
  logic error_d;
  logic cpu_hold_d;

  assign bus.byte_ready = byte_ready;
  assign xfer           = bus.byte_valid && byte_ready;
  assign ck_word        = {ck_hi_q, bus.byte_in};

  // ---------------------------------------------------------------------
  // State register (decoded outputs are registered alongside the state so
  // they line up with it exactly).
  // ---------------------------------------------------------------------
  // NOTE: non-blocking assignments in clocked blocks make every register
  // sample pre-edge values, so ordering between flops cannot create races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state      <= next_state;
      byte_ready <= byte_ready_d;
      wr_en      <= wr_en_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      cpu_hold   <= cpu_hold_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so every path assigns
  // it; a missing assignment here would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) next_state = ST_HI;
      ST_HI:    if (xfer) next_state = ST_LO;
      ST_LO:    if (xfer) next_state = ST_WRITE;
      ST_WRITE: next_state = (addr == LAST_ADDR) ? ST_CK_HI : ST_HI;
      ST_CK_HI: if (xfer) next_state = ST_CK_LO;
      ST_CK_LO: if (xfer) next_state = (ck_word == sum) ? ST_DONE : ST_ERR;
      default:  next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode: values the outputs take while in next_state.
  // ---------------------------------------------------------------------
  always_comb begin
    byte_ready_d = accepts_byte(next_state);
    wr_en_d      = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    cpu_hold_d   = 1'b1;
    case (next_state)
      ST_HI, ST_LO, ST_CK_HI, ST_CK_LO: busy_d = 1'b1;
      ST_WRITE: begin
        wr_en_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_DONE: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      ST_ERR:  error_d = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: byte latches, address, running checksum, write port.
  // wr_addr/wr_data are loaded on the low-byte transfer so they are valid
  // during the WRITE cycle and hold afterwards.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q          <= '0;
      ck_hi_q       <= '0;
      addr          <= '0;
      sum           <= '0;
      words_written <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            addr          <= '0;
            sum           <= '0;
            words_written <= '0;
          end
        end
        ST_HI: begin
          if (xfer) hi_q <= bus.byte_in;
        end
        ST_LO: begin
          if (xfer) begin
            wr_addr <= addr;
            wr_data <= {hi_q, bus.byte_in};
          end
        end
        ST_WRITE: begin
          sum           <= sum + wr_data;  // wraps mod 2^DATA_WIDTH
          words_written <= words_written + (ADDR_WIDTH + 1)'(1);
          // The address stops at the last word instead of wrapping.
          if (addr != LAST_ADDR) addr <= addr + ADDR_WIDTH'(1);
        end
        ST_CK_HI: begin
          if (xfer) ck_hi_q <= bus.byte_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 16-bit instruction memory: takes a byte stream, big-endian (high byte first), through a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words to sequential instruction addresses 0..WORD_COUNT-1, then checks a trailing 16-bit checksum.
- Holds the CPU in reset (cpu_hold) until a load completes with a matching checksum.
- Sits between the host/UART byte source and the write port of the writable instruction RAM.

Parameters:
- ADDR_WIDTH, 5, instruction address width (32-word text segment).
- DATA_WIDTH, 16, instruction width. Fixed at 16: exactly two bytes per word.
- WORD_COUNT, 32, words per load. Range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  begin a load; sampled only in IDLE, DONE or ERR.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction RAM write strobe, one cycle per word.
- wr_addr  output  ADDR_WIDTH  instruction RAM write address.
- wr_data  output  DATA_WIDTH  instruction word to write.
- cpu_hold  output  1  1 = CPU held in reset.
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- error  output  1  last load had a checksum mismatch.
- words_written  output  ADDR_WIDTH+1  words written in the current or last load.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low (rst_n). All state is registered on rising clk.
- Reset values: state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, busy=0, done=0, error=0, words_written=0, internal sum=0.
- Byte transfer: occurs on any cycle with byte_valid && byte_ready. byte_ready is a registered, state-decoded output.
- FSM states: IDLE, HI, LO, WRITE, CK_HI, CK_LO, DONE, ERR.
- IDLE: start=1 -> HI. Clear addr, sum and words_written; busy=1.
- HI: byte_ready=1. On transfer, latch hi byte -> LO.
- LO: byte_ready=1. On transfer, latch lo byte -> WRITE.
- WRITE (exactly 1 cycle):
  - byte_ready=0, wr_en=1, wr_addr=addr, wr_data={hi,lo}.
  - sum <= sum + {hi,lo} mod 2^16; words_written increments.
  - If addr==WORD_COUNT-1 -> CK_HI, else addr+1 -> HI.
- Per-word latency: the write strobe comes 1 cycle after the low-byte transfer. Minimum 3 cycles per word.
- CK_HI: byte_ready=1. On transfer, latch checksum high byte -> CK_LO.
- CK_LO: byte_ready=1. On transfer, compare {ck_hi, byte_in} with sum:
  - equal -> DONE;
  - unequal -> ERR.
- DONE: done=1, cpu_hold=0, busy=0. start -> HI (restart): done=0, cpu_hold=1 on the next edge.
- ERR: error=1, cpu_hold=1, busy=0. start -> HI: error=0.
- start while busy (states HI..CK_LO) is ignored.
- byte_valid outside the byte-accepting states: no transfer, no effect.
- Address never wraps. Transition to CK_HI happens at WORD_COUNT-1. words_written tops out at WORD_COUNT.
- Checksum arithmetic is 16-bit modulo: 0xFFFF+0x0002 = 0x0001.
- wr_addr/wr_data hold their last values when wr_en=0.
- Reset mid-load: immediate return to IDLE with cpu_hold=1. RAM contents are partial and undefined to the CPU; a new start is required.
- byte_valid stalls (0 for any number of cycles) in HI/LO/CK_* hold the state with no side effects.

Decomposition:
- Shared package imem_pkg:
  - IMEM_ADDR_WIDTH=5, IMEM_DATA_WIDTH=16, IMEM_DEPTH=32;
  - typedef imem_addr_t, imem_word_t;
  - enum loader_state_t.
- Optional sub-module imem_wr: writable 32x16 RAM with a synchronous write port (wr_en/wr_addr/wr_data) and a combinational read port (address -> instruction). Used by the bench and top level to pair with the loader.
- Loader FSM and datapath stay in a single module.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs at reset values asynchronously. byte_valid=1 with no start -> byte_ready stays 0, no wr_en.
- Nominal load, WORD_COUNT=2: start; bytes 12 34 00 01 35 12
  - -> wr_en at addr 0 with 0x1234, then addr 1 with 0x0001;
  - sum 0x1235 vs received 0x3512, mismatch -> ERR, error=1, cpu_hold=1.
  - Repeat with trailing bytes 12 35 -> DONE, done=1, cpu_hold=0, words_written=2.
- Full 32-word load with random byte_valid gaps: instruction RAM holds all 32 words in order, exactly 32 wr_en pulses, checksum wraps mod 2^16, done=1.
- Checksum wrap: words 0xFFFF, 0x0002, checksum 0x0001 -> DONE.
- Restart and ignore: start during LO -> ignored. After DONE, start -> cpu_hold=1 next cycle; second load writes from addr 0.
- Reset mid-load: assert rst_n low after 3 words -> IDLE, cpu_hold=1, words_written=0. Fresh load completes normally.
